// File: rtl/window_frame_sequencer.sv
// Frame-level controller ahead of the window line-buffer stage: starts/clears a frame, forwards
// pixels with credit-based throttling, tracks window coordinates and flags protocol errors.
module window_frame_sequencer #(
  parameter int unsigned IMG_W  = 512,
  parameter int unsigned IMG_H  = 512,
  parameter int unsigned WIN    = 6,
  parameter int unsigned NUM_LB = 7
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [7:0]                             in_pixel,
  input  logic                                   in_valid,
  input  logic                                   in_sof,
  output logic                                   in_ready,
  output logic                                   lb_clear,
  output logic [7:0]                             out_pixel,
  output logic                                   out_valid,
  input  logic                                   win_valid,
  output logic [((IMG_W > 1) ? $clog2(IMG_W) : 1)-1:0] win_x,
  output logic [((IMG_H > 1) ? $clog2(IMG_H) : 1)-1:0] win_y,
  output logic                                   win_sof,
  output logic                                   win_eol,
  output logic                                   win_eof,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   err
);

  localparam int unsigned XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned LBW = $clog2(NUM_LB + 1);

  localparam logic [XW-1:0]  XLast    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  YLast    = YW'(IMG_H - 1);
  localparam logic [YW-1:0]  WinYLast = YW'(IMG_H - WIN);
  localparam logic [LBW-1:0] LbMax    = LBW'(NUM_LB);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [XW-1:0]  col_q, col_d;
  logic [YW-1:0]  row_q, row_d;
  logic [LBW-1:0] lines_buf_q, lines_buf_d;
  logic [XW-1:0]  win_x_q, win_x_d;
  logic [YW-1:0]  win_y_q, win_y_d;
  logic [7:0]     out_pixel_q;
  logic           out_valid_q;
  logic           err_q, err_d;

  logic acc;
  logic last_px;
  logic win_window;
  logic win_act;
  logic lb_inc;
  logic lb_dec;
  logic lb_underflow;
  logic at_origin;

  // Window events only count while the window stage can legitimately produce them.
  assign win_window = (state_q == StStream) || (state_q == StDrain);
  assign win_act    = win_valid && win_window;

  assign acc       = in_valid && in_ready;
  assign at_origin = (col_q == '0) && (row_q == '0);
  assign last_px   = acc && (col_q == XLast) && (row_q == YLast);

  assign win_sof = win_act && (win_x_q == '0) && (win_y_q == '0);
  assign win_eol = win_act && (win_x_q == XLast);
  assign win_eof = win_act && (win_x_q == XLast) && (win_y_q == WinYLast);

  assign lb_inc       = acc && (col_q == XLast);
  assign lb_dec       = win_eol;
  assign lb_underflow = lb_dec && !lb_inc && (lines_buf_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StClear;
      StClear:  state_d = StStream;
      StStream: if (last_px) state_d = StDrain;
      StDrain:  if (win_eof) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State-decoded outputs; in_ready depends on registered state only.
  always_comb begin
    in_ready   = (state_q == StStream) && (lines_buf_q < LbMax);
    lb_clear   = (state_q == StClear);
    busy       = (state_q != StIdle);
    frame_done = (state_q == StDone);
  end

  // Write position
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == StClear) begin
      col_d = '0;
      row_d = '0;
    end else if (acc) begin
      if (col_q == XLast) begin
        col_d = '0;
        row_d = (row_q == YLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Line-buffer credit: simultaneous fill and release cancel out.
  always_comb begin
    lines_buf_d = lines_buf_q;
    if (state_q == StClear) begin
      lines_buf_d = '0;
    end else if (lb_inc && !lb_dec) begin
      lines_buf_d = lines_buf_q + 1'b1;
    end else if (lb_dec && !lb_inc && !lb_underflow) begin
      lines_buf_d = lines_buf_q - 1'b1;
    end
  end

  // Window coordinates
  always_comb begin
    win_x_d = win_x_q;
    win_y_d = win_y_q;
    if (state_q == StClear) begin
      win_x_d = '0;
      win_y_d = '0;
    end else if (win_act) begin
      if (win_x_q == XLast) begin
        win_x_d = '0;
        win_y_d = win_y_q + 1'b1;
      end else begin
        win_x_d = win_x_q + 1'b1;
      end
    end
  end

  // Sticky error: a new frame clears it, but errors in the same cycle still win.
  always_comb begin
    err_d = err_q;
    if ((state_q == StIdle) && start) err_d = 1'b0;
    if (acc && (in_sof != at_origin)) err_d = 1'b1;
    if (win_valid && !win_window)     err_d = 1'b1;
    if (lb_underflow)                 err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      lines_buf_q <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      out_pixel_q <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      lines_buf_q <= lines_buf_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      out_valid_q <= acc;
      if (acc) out_pixel_q <= in_pixel;
      err_q       <= err_d;
    end
  end

  assign out_pixel = out_pixel_q;
  assign out_valid = out_valid_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign err       = err_q;

endmodule
